// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory with wait states; DMEM_MISALIGN_TRAP_EN faults misaligned half/word accesses
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COMMIT, S_RESP} state_t;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic we_q;
    logic [2:0] size_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [31:0] word, bmask, wlane, rdata_nx;
    logic [7:0] b;
    logic [15:0] h;
    logic [3:0] wmask;
    logic mis, err;
    assign req_ready = state == S_IDLE;
    always_comb begin
        state_nx = state == S_IDLE   ? (req_valid ? (WAIT_STATES > 0 ? S_WAIT : S_COMMIT) : S_IDLE) :
                   state == S_WAIT   ? (cnt == 4'd0 ? S_COMMIT : S_WAIT) :
                   state == S_COMMIT ? S_RESP :
                                       (rsp_ready ? S_IDLE : S_RESP);
    end
    always_comb begin
        idx = addr_q[AW+1:2];
        word = mem[idx];
        b = 8'(word >> {addr_q[1:0], 3'b000});
        h = addr_q[1] ? word[31:16] : word[15:0];
`ifdef DMEM_MISALIGN_TRAP_EN
        mis = (size_q[1:0] == 2'b01 && addr_q[0]) || (size_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        err = (|(addr_q >> (AW + 2))) | (size_q == 3'b011) | (&size_q[2:1]) | (we_q & size_q[2]) | mis;
        wmask = size_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
                size_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        bmask = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
        wlane = size_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
                size_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
        rdata_nx = (err | we_q)         ? 32'd0 :
                   size_q[1:0] == 2'b00 ? {{24{b[7] & ~size_q[2]}}, b} :
                   size_q[1:0] == 2'b01 ? {{16{h[15] & ~size_q[2]}}, h} : word;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            cnt <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err <= 1'b0;
            we_q <= 1'b0;
            size_q <= 3'd0;
            addr_q <= 32'd0;
            wdata_q <= 32'd0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && req_valid) begin
                we_q <= req_we;
                size_q <= req_size;
                addr_q <= req_addr;
                wdata_q <= req_wdata;
                cnt <= 4'(WAIT_STATES - 1);
            end
            if (state == S_WAIT) cnt <= cnt - 4'd1;
            if (state == S_COMMIT) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= rdata_nx;
                rsp_err <= err;
                if (we_q && !err) mem[idx] <= (word & ~bmask) | (wlane & bmask);
            end
            if (state == S_RESP && rsp_ready) rsp_valid <= 1'b0;
        end
    end
endmodule
